// File: rtl/clk_divider_pkg.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// clk_divider_pkg
//   Shared clock-rate constants for the derived clocks, so game, display and
//   VGA logic can reference the same rates the divider is built with.
//   Also provides the counter-width helper used by every divider stage.
// ---------------------------------------------------------------------------
package clk_divider_pkg;

    localparam int unsigned MASTER_HZ            = 100_000_000;

    // Master cycles per half-period of each derived clock.
    localparam int unsigned ONE_HZ_HALF_DEFAULT  = 50_000_000;  // 1 Hz
    localparam int unsigned DISPLAY_HALF_DEFAULT = 100_000;     // 500 Hz
    localparam int unsigned FALL_HALF_DEFAULT    = 5_000_000;   // 10 Hz
    localparam int unsigned PIXEL_HALF_DEFAULT   = 2;           // 25 MHz

    // Counter width for a stage that counts 0 .. half-1; never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned half);
        if (half < 2) begin
            return 1;
        end
        return $clog2(half);
    endfunction

endpackage : clk_divider_pkg

// File: rtl/clk_divider_toggle.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// clk_toggle_div
//   One counter-and-toggle divider stage. clk_out is a 50% duty square wave
//   of period 2*HALF master cycles, driven straight from a flop.
//
//   Parameters:
//     HALF        master cycles per half-period (>= 1)
//   Ports:
//     master_clk  in   master clock, rising-edge logic
//     rst         in   asynchronous active-high reset (counter and output 0)
//     clk_out     out  divided square wave
// ---------------------------------------------------------------------------
module clk_toggle_div
    import clk_divider_pkg::*;
#(
    parameter int unsigned HALF = 2
) (
    input  logic master_clk,
    input  logic rst,
    output logic clk_out
);

    localparam int unsigned W = cnt_width(HALF);
    localparam logic [W-1:0] TERM = W'(HALF - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         clk_q;
    logic         clk_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        clk_d = clk_q;
        if (cnt_q == TERM) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule : clk_toggle_div

// File: rtl/clk_divider.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// clk_divider
//   Produces four free-running 50% duty derived clocks from the master clock.
//   Each output comes from its own independent toggle stage; outputs may
//   toggle on the same edge with no interaction between them.
//
//   Parameters (master cycles per half-period):
//     ONE_HZ_HALF, DISPLAY_HALF, FALL_HALF, PIXEL_HALF
//   Ports:
//     master_clk   in   master clock (100 MHz), rising-edge logic
//     rst          in   asynchronous active-high reset
//     one_hz_clk   out  1 Hz timer square wave
//     display_clk  out  7-segment scan square wave
//     fall_clk     out  block-fall game square wave
//     pixel_clk    out  VGA pixel square wave
// ---------------------------------------------------------------------------
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int unsigned ONE_HZ_HALF  = ONE_HZ_HALF_DEFAULT,
    parameter int unsigned DISPLAY_HALF = DISPLAY_HALF_DEFAULT,
    parameter int unsigned FALL_HALF    = FALL_HALF_DEFAULT,
    parameter int unsigned PIXEL_HALF   = PIXEL_HALF_DEFAULT
) (
    input  logic master_clk,
    input  logic rst,
    output logic one_hz_clk,
    output logic display_clk,
    output logic fall_clk,
    output logic pixel_clk
);

    clk_toggle_div #(.HALF(ONE_HZ_HALF)) u_one_hz (
        .master_clk (master_clk),
        .rst        (rst),
        .clk_out    (one_hz_clk)
    );

    clk_toggle_div #(.HALF(DISPLAY_HALF)) u_display (
        .master_clk (master_clk),
        .rst        (rst),
        .clk_out    (display_clk)
    );

    clk_toggle_div #(.HALF(FALL_HALF)) u_fall (
        .master_clk (master_clk),
        .rst        (rst),
        .clk_out    (fall_clk)
    );

    clk_toggle_div #(.HALF(PIXEL_HALF)) u_pixel (
        .master_clk (master_clk),
        .rst        (rst),
        .clk_out    (pixel_clk)
    );

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
`timescale 1ns/100ps
module tb_clk_divider;

    logic master_clk = 1'b0;
    logic rst;

    logic one_hz_a, display_a, fall_a, pixel_a;
    logic one_hz_b, display_b, fall_b, pixel_b;
    logic [7:0] obs;

    int checks   = 0;
    int failures = 0;

    // Index order: A one_hz, display, fall, pixel, then B likewise.
    int unsigned HALVES    [8] = '{10, 4, 3, 2, 5, 7, 1, 1};
    int unsigned FIRST_EXP [8] = '{10, 4, 3, 2, 5, 7, 1, 1};
    int unsigned PERIOD_EXP[8] = '{20, 8, 6, 4, 10, 14, 2, 2};
    int unsigned RISES_EXP [8] = '{20, 50, 67, 100, 40, 29, 200, 200};
    string       NAMES     [8] = '{"a_one_hz", "a_display", "a_fall", "a_pixel",
                                   "b_one_hz", "b_display", "b_fall", "b_pixel"};

    always #1 master_clk = ~master_clk;

    clk_divider #(
        .ONE_HZ_HALF  (10),
        .DISPLAY_HALF (4),
        .FALL_HALF    (3),
        .PIXEL_HALF   (2)
    ) dut_a (
        .master_clk  (master_clk),
        .rst         (rst),
        .one_hz_clk  (one_hz_a),
        .display_clk (display_a),
        .fall_clk    (fall_a),
        .pixel_clk   (pixel_a)
    );

    clk_divider #(
        .ONE_HZ_HALF  (5),
        .DISPLAY_HALF (7),
        .FALL_HALF    (1),
        .PIXEL_HALF   (1)
    ) dut_b (
        .master_clk  (master_clk),
        .rst         (rst),
        .one_hz_clk  (one_hz_b),
        .display_clk (display_b),
        .fall_clk    (fall_b),
        .pixel_clk   (pixel_b)
    );

    assign obs = {pixel_b, fall_b, display_b, one_hz_b,
                  pixel_a, fall_a, display_a, one_hz_a};

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic chk_int(input string tag, input int unsigned observed,
                           input int unsigned expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Level of a HALF-divided clock after k rising edges since reset release.
    function automatic logic exp_clk(input int unsigned k, input int unsigned half);
        return ((k / half) % 2) == 1;
    endfunction

    // Runs n edges right after a reset release, checking every output level
    // after each edge; optionally checks first-rise latency, rise-to-rise
    // period and the total number of rising edges.
    task automatic run_seq(input int unsigned n, input string tag,
                           input bit timing, input bit count_rises);
        int unsigned first [8];
        int unsigned second[8];
        int unsigned rises [8];
        logic [7:0]  prev;
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            first[i]  = 0;
            second[i] = 0;
            rises[i]  = 0;
        end
        for (int unsigned k = 1; k <= n; k++) begin
            @(negedge master_clk);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s_%s_k%0d", tag, NAMES[i], k), obs[i],
                    exp_clk(k, HALVES[i]));
                if (obs[i] && !prev[i]) begin
                    rises[i]++;
                    if (first[i] == 0)       first[i]  = k;
                    else if (second[i] == 0) second[i] = k;
                end
            end
            prev = obs;
        end
        for (int i = 0; i < 8; i++) begin
            if (timing) begin
                chk_int($sformatf("%s_%s_first_rise", tag, NAMES[i]), first[i], FIRST_EXP[i]);
                chk_int($sformatf("%s_%s_period", tag, NAMES[i]), second[i] - first[i],
                        PERIOD_EXP[i]);
            end
            if (count_rises) begin
                chk_int($sformatf("%s_%s_rises", tag, NAMES[i]), rises[i], RISES_EXP[i]);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_%s", tag, NAMES[i]), obs[i], 1'b0);
        end
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for 100 ns with the clock running.
        rst = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge master_clk);
            chk_all_zero($sformatf("rst_hold_%0d", n));
        end

        // Release: latency, per-edge levels, period.
        rst = 1'b0;
        run_seq(48, "rel1", 1'b1, 1'b0);

        // Restart and run to edge 15, where every dut_a output is high.
        rst = 1'b1;
        @(negedge master_clk);
        chk_all_zero("pulse1");
        rst = 1'b0;
        run_seq(15, "pre_async", 1'b0, 1'b0);

        // Assert reset between edges: outputs must clear before the next edge.
        #0.3 rst = 1'b1;
        #0.2 chk_all_zero("async_rst");
        @(negedge master_clk);
        chk_all_zero("async_hold1");
        @(negedge master_clk);
        chk_all_zero("async_hold2");

        // Timing after release must repeat exactly.
        rst = 1'b0;
        run_seq(48, "rel2", 1'b1, 1'b0);

        // Longer run: count periods.
        rst = 1'b1;
        @(negedge master_clk);
        rst = 1'b0;
        run_seq(400, "long", 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_divider

// File: doc/clk_divider.md
Name: clk_divider

Overview:
- Generates four free-running, 50%-duty derived clocks from the single board master clock (100 MHz): 1 Hz timer tick, 7-segment display scan clock, block-fall game clock and VGA pixel clock.
- Sits at the top of the design; all game, display and VGA logic consume its outputs.
- Each output is produced by an independent counter-and-toggle stage with its own half-period parameter.

Parameters:
- ONE_HZ_HALF, 50_000_000, master cycles per half-period of one_hz_clk (100 MHz / (2 × 50e6) = 1 Hz).
- DISPLAY_HALF, 100_000, master cycles per half-period of display_clk (500 Hz).
- FALL_HALF, 5_000_000, master cycles per half-period of fall_clk (10 Hz).
- PIXEL_HALF, 2, master cycles per half-period of pixel_clk (25 MHz).
- All parameters are integers ≥ 1. Counter width is derived as $clog2 of the parameter, minimum 1 bit.

Ports:
- master_clk  input  1  master clock, 100 MHz; all logic is on its rising edge.
- rst  input  1  reset; asynchronous and active-high.
- one_hz_clk  output  1  1 Hz square wave.
- display_clk  output  1  display scan square wave.
- fall_clk  output  1  game fall-rate square wave.
- pixel_clk  output  1  VGA pixel square wave.

Behaviour:
- One clock (master_clk); reset is asynchronous and active-high (rst).
- While rst=1, all counters and all four outputs are 0 immediately, without waiting for a clock edge.
- Each stage X has counter cnt_X and output reg X_clk.
- On each rising master_clk edge with rst=0:
  - If cnt_X == X_HALF-1: cnt_X is set to 0 and X_clk is inverted.
  - Otherwise cnt_X increments by 1.
- Output frequency is f_master / (2·X_HALF). Duty cycle is exactly 50%. Period is exactly 2·X_HALF master cycles, with no drift.
- Latency: after rst falls, the first 0→1 transition of X_clk happens on the X_HALF-th rising master edge. Subsequent transitions follow every X_HALF edges.
- X_HALF=1 means X_clk toggles on every edge (f_master/2).
- Stages are mutually independent. Two or more outputs may toggle on the same edge; there is no priority or interaction between them.
- Reset asserted mid-period returns every counter and output to 0 at once. After release, timing restarts from 0 exactly as after power-up.
- Outputs are registered, with no combinational path from rst or master_clk to any output except the asynchronous reset.
- Outputs are intended as clock-enable-style timing sources. No glitches are permitted because outputs are driven directly from flops.

Decomposition:
- Shared package: default constants MASTER_HZ=100_000_000 and the four default half-period values, so that game and VGA blocks can reference the rates.
- One natural sub-module: clk_toggle_div (parameter HALF; ports master_clk, rst, clk_out). It implements a single counter/toggle stage. clk_divider instantiates it four times.

Test Plan:
- Small parameters for simulation: ONE_HZ_HALF=10, DISPLAY_HALF=4, FALL_HALF=3, PIXEL_HALF=2; master_clk period 2 ns.
- Reset hold: rst=1 for 100 ns with the clock running -> all four outputs remain 0 throughout.
- Reset release: drop rst -> pixel_clk rises on the 2nd edge, fall_clk on the 3rd, display_clk on the 4th, one_hz_clk on the 10th.
- Steady-state period check: measure rising-to-rising intervals -> 4/6/8/20 master cycles for pixel/fall/display/one_hz respectively. High time equals low time in each case.
- Async reset mid-operation: assert rst between clock edges while outputs are high -> all outputs go 0 immediately. After release, the rising-edge latency from the reset-release check is repeated exactly.
- HALF=1 corner: instantiate with PIXEL_HALF=1 -> pixel_clk toggles on every master edge after reset release (f_master/2).
- Long run with default parameters, 2,000,000 cycles -> pixel_clk shows 500,000 periods and display_clk shows exactly 10 periods.
